// File: rtl/game_pkg.sv
// game_pkg: scene codes and coordinate constants shared by player, enemy, bullet and render blocks
package game_pkg;
    localparam int COORD_W = 9;
    localparam int OFF_Y_DEFAULT = 300;
    localparam logic [1:0] SCENE_MENU = 2'd0;
    localparam logic [1:0] SCENE_PLAY = 2'd1;
    localparam logic [1:0] SCENE_OVER = 2'd2;
endpackage

// File: rtl/free_slot_picker.sv
// free_slot_picker: first free slot at or after rr_ptr, wrapping round the pool
module free_slot_picker #(
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_W = $clog2(NUM_SLOTS)
) (
    input  logic [NUM_SLOTS-1:0] busy,
    input  logic [SLOT_W-1:0]    rr_ptr,
    output logic                 found,
    output logic [SLOT_W-1:0]    index
);
    logic [SLOT_W-1:0] idx;
    // scan from furthest to nearest so the free slot closest to rr_ptr wins
    always_comb begin
        found = 1'b0;
        index = '0;
        idx = '0;
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            idx = SLOT_W'((int'(rr_ptr) + k) % NUM_SLOTS);
            if (!busy[idx]) begin
                found = 1'b1;
                index = idx;
            end
        end
    end
endmodule

// File: rtl/bullet_pool_ctrl.sv
// bullet_pool_ctrl: round-robin player bullet pool; define BULLET_COOLDOWN_EN for a fire cooldown
module bullet_pool_ctrl
    import game_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int SPAWN_Y = 215,
    parameter int OFF_Y = OFF_Y_DEFAULT,
    parameter int X_OFFSET = 7,
    parameter int COOLDOWN = 32,
    parameter int SLOT_W = $clog2(NUM_SLOTS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clk_en,
    input  logic [1:0]                     scene,
    input  logic                           fire_re,
    input  logic [COORD_W-1:0]             player_X,
    input  logic                           hit_valid,
    input  logic [SLOT_W-1:0]              hit_slot,
    output logic [NUM_SLOTS-1:0]           slot_active,
    output logic [COORD_W*NUM_SLOTS-1:0]   slot_X,
    output logic [COORD_W*NUM_SLOTS-1:0]   slot_Y,
    output logic                           fire_ack,
    output logic [SLOT_W-1:0]              fire_slot,
    output logic                           pool_full
);
    localparam logic [COORD_W-1:0] PARK = COORD_W'(OFF_Y);
    localparam logic [COORD_W-1:0] SPAWN = COORD_W'(SPAWN_Y);

    logic [COORD_W-1:0] x_q [NUM_SLOTS];
    logic [COORD_W-1:0] y_q [NUM_SLOTS];
    logic [COORD_W-1:0] x_n [NUM_SLOTS];
    logic [COORD_W-1:0] y_n [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] busy, active_q;
    logic [SLOT_W-1:0] rr_ptr, pick;
    logic found, play, cd_ok, fire_ok;

    assign play = scene == SCENE_PLAY;
    assign pool_full = &busy;
    assign fire_ok = fire_re && play && found && cd_ok;
    assign slot_active = active_q;

`ifdef BULLET_COOLDOWN_EN
    logic [7:0] cooldown;
    assign cd_ok = cooldown == 8'd0;
    // reload on an accepted shot, count down on movement ticks, cleared outside play
    always_ff @(posedge clk) begin
        if (!rst_n || !play)
            cooldown <= '0;
        else if (fire_ok)
            cooldown <= 8'(COOLDOWN);
        else if (clk_en && cooldown != 8'd0)
            cooldown <= cooldown - 8'd1;
    end
`else
    assign cd_ok = 1'b1;
`endif

    // a slot is in flight whenever its Y is not parked
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++)
            busy[i] = y_q[i] != PARK;
    end

    free_slot_picker #(.NUM_SLOTS(NUM_SLOTS), .SLOT_W(SLOT_W)) u_picker (
        .busy   (busy),
        .rr_ptr (rr_ptr),
        .found  (found),
        .index  (pick)
    );

    // per-slot next state: scene park, hit, top-edge retire, move, then spawn into a free slot
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            x_n[i] = x_q[i];
            y_n[i] = y_q[i];
            if (!play || (hit_valid && hit_slot == SLOT_W'(i) && busy[i]) || (busy[i] && y_q[i] == '0))
                y_n[i] = PARK;
            else if (busy[i])
                y_n[i] = clk_en ? y_q[i] - 1'b1 : y_q[i];
            else if (fire_ok && pick == SLOT_W'(i)) begin
                x_n[i] = COORD_W'(int'(player_X) + X_OFFSET);
                y_n[i] = SPAWN;
            end
        end
    end

    // slot registers, registered active decode, allocation pointer and fire handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= PARK;
            end
            active_q <= '0;
            rr_ptr <= '0;
            fire_ack <= 1'b0;
            fire_slot <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_q[i] <= x_n[i];
                y_q[i] <= y_n[i];
                active_q[i] <= y_n[i] != PARK;
            end
            fire_ack <= fire_ok;
            if (fire_ok) begin
                fire_slot <= pick;
                rr_ptr <= (pick == SLOT_W'(NUM_SLOTS - 1)) ? '0 : pick + 1'b1;
            end
        end
    end

    // pack slot coordinates for the renderer
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_X[COORD_W*i +: COORD_W] = x_q[i];
            slot_Y[COORD_W*i +: COORD_W] = y_q[i];
        end
    end
endmodule

// File: tb/tb_bullet_pool_ctrl.sv
// tb_bullet_pool_ctrl: directed stimulus with a slot-pool model checked every cycle
module tb_bullet_pool_ctrl;
    localparam int NS = 4;
    localparam int SW = 2;
    localparam int OFF = 300;
    localparam logic [1:0] PLAY = 2'd1;
    localparam logic [1:0] MENU = 2'd0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clk_en = 1'b0;
    logic [1:0] scene = MENU;
    logic fire_re = 1'b0;
    logic [8:0] player_X = '0;
    logic hit_valid = 1'b0;
    logic [SW-1:0] hit_slot = '0;
    logic [NS-1:0] slot_active;
    logic [9*NS-1:0] slot_X, slot_Y;
    logic fire_ack;
    logic [SW-1:0] fire_slot;
    logic pool_full;

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    int mx [NS];
    int my [NS];
    int mptr = 0;
    int mslot = 0;
    int mcd = 0;
    bit mack = 0;

    logic [9*NS-1:0] ex, ey;
    logic [NS-1:0] ea;

    bullet_pool_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_en      (clk_en),
        .scene       (scene),
        .fire_re     (fire_re),
        .player_X    (player_X),
        .hit_valid   (hit_valid),
        .hit_slot    (hit_slot),
        .slot_active (slot_active),
        .slot_X      (slot_X),
        .slot_Y      (slot_Y),
        .fire_ack    (fire_ack),
        .fire_slot   (fire_slot),
        .pool_full   (pool_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // one clock: apply inputs, predict the pool from the rules, advance, commit the prediction
    task automatic step(input bit f, input bit h, input int hs, input bit en);
        int nx [NS];
        int ny [NS];
        int pick, ncd;
        bit ok;
        fire_re = f;
        hit_valid = h;
        hit_slot = hs[SW-1:0];
        clk_en = en;
        pick = -1;
        for (int k = 0; k < NS && pick < 0; k++)
            if (my[(mptr + k) % NS] == OFF) pick = (mptr + k) % NS;
        ok = f && scene == PLAY && pick >= 0 && mcd == 0;
        ncd = mcd;
        for (int i = 0; i < NS; i++) begin
            nx[i] = mx[i];
            ny[i] = my[i];
            if (scene != PLAY) ny[i] = OFF;
            else if (my[i] != OFF) begin
                if (h && hs == i) ny[i] = OFF;
                else if (my[i] == 0) ny[i] = OFF;
                else if (en) ny[i] = my[i] - 1;
            end else if (ok && pick == i) begin
                nx[i] = (player_X + 7) % 512;
                ny[i] = 215;
            end
        end
`ifdef BULLET_COOLDOWN_EN
        if (scene != PLAY) ncd = 0;
        else if (ok) ncd = 32;
        else if (en && mcd > 0) ncd = mcd - 1;
`endif
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < NS; i++) begin
                mx[i] = 0;
                my[i] = OFF;
            end
            mptr = 0; mslot = 0; mack = 0; mcd = 0;
        end else begin
            mx = nx;
            my = ny;
            mcd = ncd;
            mack = ok;
            if (ok) begin
                mslot = pick;
                mptr = (pick + 1) % NS;
            end
        end
        #1;
        fire_re = 0;
        hit_valid = 0;
        clk_en = 0;
    endtask

    // compare every output against the model away from the clock edge
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < NS; i++) begin
                ex[9*i +: 9] = 9'(mx[i]);
                ey[9*i +: 9] = 9'(my[i]);
                ea[i] = my[i] != OFF;
            end
            chk("slot_X", 64'(slot_X), 64'(ex));
            chk("slot_Y", 64'(slot_Y), 64'(ey));
            chk("slot_active", 64'(slot_active), 64'(ea));
            chk("pool_full", 64'(pool_full), 64'(&ea));
            chk("fire_ack", 64'(fire_ack), 64'(mack));
            chk("fire_slot", 64'(fire_slot), 64'(mslot));
        end
    end

    initial begin
        rst_n = 0;
        step(0, 0, 0, 0);
        chk_on = 1;
        step(0, 0, 0, 0);
        chk("rst_y", 64'(slot_Y), 64'({4{9'd300}}));
        chk("rst_active", 64'(slot_active), 64'd0);
        chk("rst_ack", 64'(fire_ack), 64'd0);
        rst_n = 1;
        for (int n = 0; n < 10; n++) step(0, 0, 0, 1);
        chk("idle_y", 64'(slot_Y), 64'({4{9'd300}}));
        chk("idle_x", 64'(slot_X), 64'd0);

        scene = PLAY;
        player_X = 9'd100;
        step(1, 0, 0, 0);
        chk("fire0_x", 64'(slot_X[8:0]), 64'd107);
        chk("fire0_y", 64'(slot_Y[8:0]), 64'd215);
        chk("fire0_ack", 64'(fire_ack), 64'd1);
        chk("fire0_slot", 64'(fire_slot), 64'd0);
        for (int n = 0; n < 3; n++) step(0, 0, 0, 1);
        chk("move_y", 64'(slot_Y[8:0]), 64'd212);
        chk("move_x", 64'(slot_X[8:0]), 64'd107);

`ifndef BULLET_COOLDOWN_EN
        for (int n = 1; n < 4; n++) begin
            step(1, 0, 0, 0);
            chk("fill_slot", 64'(fire_slot), 64'(n));
        end
        chk("full", 64'(pool_full), 64'd1);
        step(1, 0, 0, 0);
        chk("full_reject_ack", 64'(fire_ack), 64'd0);
        chk("full_reject_active", 64'(slot_active), 64'hf);

        step(1, 1, 2, 0);
        chk("hit_active", 64'(slot_active), 64'b1011);
        chk("hit_no_ack", 64'(fire_ack), 64'd0);
        chk("hit_y", 64'(slot_Y[26:18]), 64'd300);
        step(1, 0, 0, 0);
        chk("refire_slot", 64'(fire_slot), 64'd2);
        chk("refire_ack", 64'(fire_ack), 64'd1);

        for (int n = 0; n < 211; n++) step(0, 0, 0, 1);
        chk("near_top", 64'(slot_Y[8:0]), 64'd1);
        step(0, 0, 0, 1);
        chk("at_top", 64'(slot_Y[8:0]), 64'd0);
        step(0, 0, 0, 0);
        chk("retire_y", 64'(slot_Y[8:0]), 64'd300);
        chk("others_y", 64'(slot_Y[35:9]), 64'({3{9'd3}}));
        player_X = 9'd510;
        step(1, 0, 0, 0);
        chk("wrap_slot", 64'(fire_slot), 64'd0);
        chk("wrap_x", 64'(slot_X[8:0]), 64'd5);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("hit_idle_slot", 64'(slot_active), 64'b1110);
`endif

        scene = MENU;
        step(1, 0, 0, 1);
        chk("menu_y", 64'(slot_Y), 64'({4{9'd300}}));
        chk("menu_active", 64'(slot_active), 64'd0);
        chk("menu_ack", 64'(fire_ack), 64'd0);

`ifdef BULLET_COOLDOWN_EN
        scene = PLAY;
        player_X = 9'd40;
        step(1, 0, 0, 0);
        chk("cd_first", 64'(fire_ack), 64'd1);
        for (int n = 0; n < 31; n++) step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        chk("cd_reject", 64'(fire_ack), 64'd0);
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        chk("cd_accept", 64'(fire_ack), 64'd1);
        scene = MENU;
        step(0, 0, 0, 0);
        chk("cd_menu_active", 64'(slot_active), 64'd0);
        scene = PLAY;
        step(1, 0, 0, 0);
        chk("cd_cleared", 64'(fire_ack), 64'd1);
`endif

        step(0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
